// File: rtl/gems2mm_v2.sv
// AXI-Stream to AXI4 memory-mapped read bridge: stream words are buffered in a
// FIFO and drained by AXI4 read bursts; a second address region reports FIFO fill.
module gems2mm_v2 #(
    parameter int unsigned C_AXI_ID_WIDTH = 1,
    parameter int unsigned FIFO_AW        = 9,
    localparam int unsigned C_AXI_DATA_WIDTH = 32,
    localparam int unsigned C_AXI_ADDR_WIDTH = 13
) (
    input  logic                        ACLK,
    input  logic                        ARESET,
    input  logic [C_AXI_ID_WIDTH-1:0]   S_AXI_ARID,
    input  logic [C_AXI_ADDR_WIDTH-1:0] S_AXI_ARADDR,
    input  logic [7:0]                  S_AXI_ARLEN,
    input  logic [2:0]                  S_AXI_ARSIZE,
    input  logic [1:0]                  S_AXI_ARBURST,
    input  logic                        S_AXI_ARVALID,
    output logic                        S_AXI_ARREADY,
    output logic [C_AXI_ID_WIDTH-1:0]   S_AXI_RID,
    output logic [C_AXI_DATA_WIDTH-1:0] S_AXI_RDATA,
    output logic [1:0]                  S_AXI_RRESP,
    output logic                        S_AXI_RLAST,
    output logic                        S_AXI_RVALID,
    input  logic                        S_AXI_RREADY,
    input  logic [C_AXI_DATA_WIDTH-1:0] S_AXIS_TDATA,
    input  logic                        S_AXIS_TLAST,
    input  logic                        S_AXIS_TVALID,
    output logic                        S_AXIS_TREADY
);

    localparam int unsigned      DEPTH       = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] LVL_FULL    = {1'b1, {FIFO_AW{1'b0}}};
    localparam logic [2:0]       SIZE_4B     = 3'b010;
    localparam logic [1:0]       RESP_OKAY   = 2'b00;
    localparam logic [1:0]       RESP_SLVERR = 2'b10;

    typedef enum logic {ST_IDLE, ST_BURST} state_t;

    state_t                      r_state, w_state_nxt;
    logic [32:0]                 r_mem [DEPTH];
    logic [FIFO_AW-1:0]          r_wptr, r_rptr;
    logic [FIFO_AW:0]            r_level;
    logic                        r_arready, w_arready_nxt;
    logic [C_AXI_ID_WIDTH-1:0]   r_rid;
    logic [8:0]                  r_beats;
    logic                        r_region, r_err;
    logic                        r_rvalid, r_rlast;
    logic [31:0]                 r_rdata;
    logic [1:0]                  r_rresp;

    logic                        w_full, w_empty, w_push, w_pop;
    logic                        w_ar_hs, w_load, w_r_done;
    logic [32:0]                 w_head;
    logic [15:0]                 w_level16;
    logic [31:0]                 w_beat_data;
    logic [1:0]                  w_beat_resp;
    logic                        w_unused;

    assign w_unused      = ^{S_AXI_ARBURST, S_AXI_ARADDR[11:0]};
    assign w_full        = (r_level == LVL_FULL);
    assign w_empty       = (r_level == '0);
    assign S_AXIS_TREADY = !w_full && !ARESET;
    assign w_push        = S_AXIS_TVALID && S_AXIS_TREADY;
    assign w_head        = r_mem[r_rptr];
    assign w_level16     = 16'(r_level);

    assign w_ar_hs  = S_AXI_ARVALID && r_arready;
    assign w_load   = (r_state == ST_BURST) && (!r_rvalid || S_AXI_RREADY) && (r_beats != '0);
    assign w_r_done = r_rvalid && S_AXI_RREADY && r_rlast;

    // ARREADY is registered so it lags the return to IDLE by one edge.
    always_comb begin
        w_state_nxt   = r_state;
        w_arready_nxt = r_arready;
        case (r_state)
            ST_IDLE: begin
                if (w_ar_hs) begin
                    w_state_nxt   = ST_BURST;
                    w_arready_nxt = 1'b0;
                end else begin
                    w_arready_nxt = 1'b1;
                end
            end
            ST_BURST: begin
                w_arready_nxt = 1'b0;
                if (w_r_done) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_beat_data = '0;
        w_beat_resp = RESP_OKAY;
        w_pop       = 1'b0;
        if (r_err) begin
            w_beat_resp = RESP_SLVERR;
        end else if (r_region) begin
            w_beat_data = {(w_empty ? 1'b0 : w_head[32]), 15'b0, w_level16};
        end else if (!w_empty) begin
            w_beat_data = w_head[31:0];
            w_pop       = w_load;
        end else begin
            w_beat_resp = RESP_SLVERR;
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_state   <= ST_IDLE;
            r_arready <= 1'b0;
            r_rid     <= '0;
            r_beats   <= '0;
            r_region  <= 1'b0;
            r_err     <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rlast   <= 1'b0;
            r_rdata   <= '0;
            r_rresp   <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_arready <= w_arready_nxt;
            if (w_ar_hs) begin
                r_rid    <= S_AXI_ARID;
                r_beats  <= {1'b0, S_AXI_ARLEN} + 9'd1;
                r_region <= S_AXI_ARADDR[12];
                r_err    <= (S_AXI_ARSIZE != SIZE_4B);
            end else if (w_load) begin
                r_beats <= r_beats - 9'd1;
            end
            if (w_load) begin
                r_rvalid <= 1'b1;
                r_rdata  <= w_beat_data;
                r_rresp  <= w_beat_resp;
                r_rlast  <= (r_beats == 9'd1);
            end else if (S_AXI_RREADY) begin
                r_rvalid <= 1'b0;
            end
        end
    end

    always_ff @(posedge ACLK) begin
        if (w_push) r_mem[r_wptr] <= {S_AXIS_TLAST, S_AXIS_TDATA};
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    assign S_AXI_ARREADY = r_arready;
    assign S_AXI_RID     = r_rid;
    assign S_AXI_RDATA   = r_rdata;
    assign S_AXI_RRESP   = r_rresp;
    assign S_AXI_RLAST   = r_rlast;
    assign S_AXI_RVALID  = r_rvalid;

endmodule

// File: tb/tb_gems2mm_v2.sv
// Directed bench for gems2mm_v2: a default-depth instance plus a depth-4 instance
// sharing the AR/R channel, with a separate stream feeder for the small one.
module tb_gems2mm_v2;

    logic        ACLK = 1'b0;
    logic        ARESET;
    logic        arid, arvalid, arready, rid, rlast, rvalid, rready;
    logic [12:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst, rresp;
    logic [31:0] rdata, tdata;
    logic        tlast, tvalid, tready;
    logic        arready_s, rid_s, rlast_s, rvalid_s;
    logic [1:0]  rresp_s;
    logic [31:0] rdata_s, tdata_s;
    logic        tlast_s, tvalid_s, tready_s;

    always #5 ACLK = ~ACLK;

    gems2mm_v2 #(.C_AXI_ID_WIDTH(1), .FIFO_AW(9)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .S_AXI_ARID(arid), .S_AXI_ARADDR(araddr), .S_AXI_ARLEN(arlen),
        .S_AXI_ARSIZE(arsize), .S_AXI_ARBURST(arburst),
        .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
        .S_AXI_RID(rid), .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp),
        .S_AXI_RLAST(rlast), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
        .S_AXIS_TDATA(tdata), .S_AXIS_TLAST(tlast),
        .S_AXIS_TVALID(tvalid), .S_AXIS_TREADY(tready)
    );

    gems2mm_v2 #(.C_AXI_ID_WIDTH(1), .FIFO_AW(2)) dut_s (
        .ACLK(ACLK), .ARESET(ARESET),
        .S_AXI_ARID(arid), .S_AXI_ARADDR(araddr), .S_AXI_ARLEN(arlen),
        .S_AXI_ARSIZE(arsize), .S_AXI_ARBURST(arburst),
        .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready_s),
        .S_AXI_RID(rid_s), .S_AXI_RDATA(rdata_s), .S_AXI_RRESP(rresp_s),
        .S_AXI_RLAST(rlast_s), .S_AXI_RVALID(rvalid_s), .S_AXI_RREADY(rready),
        .S_AXIS_TDATA(tdata_s), .S_AXIS_TLAST(tlast_s),
        .S_AXIS_TVALID(tvalid_s), .S_AXIS_TREADY(tready_s)
    );

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [31:0] g_data [16];
    logic [1:0]  g_resp [16];
    logic        g_last [16];
    logic        g_id   [16];
    logic [31:0] g_sdata[16];
    logic [1:0]  g_sresp[16];
    int          g_nb, g_lat, g_cyc;

    task automatic push(input logic [31:0] d, input logic l);
        int unsigned c = 0;
        tdata = d; tlast = l; tvalid = 1'b1;
        while (!tready && c < 50) begin @(negedge ACLK); c++; end
        if (!tready) check("push_timeout", 64'(tready), 64'd1);
        @(negedge ACLK);
        tvalid = 1'b0;
    endtask

    // Issues one AR and collects every R beat; checks R stability on stalls.
    task automatic rd_burst(input logic [12:0] addr, input int len, input logic [2:0] size,
                            input logic id, input bit stall);
        int unsigned c = 0;
        bit          first = 1'b1;
        bit          held = 1'b0;
        logic [63:0] hold = '0;
        araddr = addr; arlen = 8'(len); arsize = size; arid = id; arvalid = 1'b1;
        while (!arready && c < 20) begin @(negedge ACLK); c++; end
        if (!arready) check("ar_timeout", 64'(arready), 64'd1);
        @(negedge ACLK);
        arvalid = 1'b0;
        g_nb = 0; g_cyc = 0; g_lat = -1;
        while (g_nb <= len && g_cyc < 300) begin
            if (rvalid) begin
                if (first) begin g_lat = g_cyc; first = 1'b0; end
                if (rready) begin
                    g_data[g_nb] = rdata; g_resp[g_nb] = rresp; g_last[g_nb] = rlast;
                    g_id[g_nb] = rid; g_sdata[g_nb] = rdata_s; g_sresp[g_nb] = rresp_s;
                    g_nb++;
                end else begin
                    hold = 64'({rid, rlast, rresp, rdata});
                    held = 1'b1;
                end
            end
            @(negedge ACLK);
            g_cyc++;
            if (held) begin
                check("r_hold", 64'({rid, rlast, rresp, rdata}), hold);
                held = 1'b0;
            end
            if (stall) rready = 1'($urandom_range(0, 1));
        end
        if (g_nb <= len) check("r_timeout", 64'(g_nb), 64'(len + 1));
        rready = 1'b1;
    endtask

    int unsigned n_acc = 0;
    bit          feed_on = 1'b0;
    initial begin
        bit acc = 1'b0;
        bit started = 1'b0;
        forever begin
            @(negedge ACLK);
            if (acc) begin
                n_acc++;
                if (n_acc < 6) tdata_s = 32'hB0 + n_acc;
                else           tvalid_s = 1'b0;
            end
            if (feed_on && !started) begin
                tdata_s = 32'hB0; tvalid_s = 1'b1; started = 1'b1;
            end
            acc = tvalid_s && tready_s;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] exp_d[4];
        logic [1:0]  exp_r[4];
        int          c;
        ARESET = 1'b1; arid = 0; araddr = '0; arlen = '0; arsize = 3'b010; arburst = 2'b01;
        arvalid = 0; rready = 1; tdata = '0; tlast = 0; tvalid = 0;
        tdata_s = '0; tlast_s = 0; tvalid_s = 0;
        #1;
        check("rst_arready", 64'(arready), 64'd0);
        check("rst_rvalid",  64'(rvalid),  64'd0);
        check("rst_rout",    64'({rid, rlast, rresp, rdata}), 64'd0);
        check("rst_tready",  64'(tready),  64'd0);
        repeat (2) @(negedge ACLK);
        ARESET = 1'b0;
        check("arready_pre", 64'(arready), 64'd0);
        @(negedge ACLK);
        check("arready_rise", 64'(arready), 64'd1);

        // Basic drain
        for (int i = 0; i < 4; i++) push(32'hA0 + i, 1'(i == 3));
        rd_burst(13'h000, 3, 3'b010, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            check("basic_data", 64'(g_data[i]), 64'(32'hA0 + i));
            check("basic_resp_last", 64'({g_resp[i], g_last[i]}), 64'({2'b00, 1'(i == 3)}));
        end
        check("basic_rid", 64'(g_id[0]), 64'd1);
        check("ar_latency", 64'(g_lat), 64'd1);
        check("throughput", 64'(g_cyc), 64'd5);
        check("turn_arready0", 64'(arready), 64'd0);
        @(negedge ACLK);
        check("turn_arready1", 64'(arready), 64'd1);
        rd_burst(13'h1000, 0, 3'b010, 1'b0, 1'b0);
        check("basic_level0", 64'(g_data[0]), 64'h0);

        // Status read
        for (int i = 0; i < 5; i++) push(32'hD0 + i, 1'(i == 0));
        rd_burst(13'h1000, 0, 3'b010, 1'b0, 1'b0);
        check("status_word", 64'({g_resp[0], g_data[0]}), 64'({2'b00, 32'h8000_0005}));
        rd_burst(13'h000, 4, 3'b010, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++)
            check("status_drain", 64'({g_resp[i], g_data[i]}), 64'({2'b00, 32'hD0 + i}));

        // Underflow
        push(32'hE0, 1'b0); push(32'hE1, 1'b0);
        exp_d = '{32'hE0, 32'hE1, 32'h0, 32'h0};
        exp_r = '{2'b00, 2'b00, 2'b10, 2'b10};
        rd_burst(13'h000, 3, 3'b010, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++)
            check("underflow", 64'({g_last[i], g_resp[i], g_data[i]}),
                  64'({1'(i == 3), exp_r[i], exp_d[i]}));

        // Bad size, then stalled drain
        for (int i = 0; i < 4; i++) push(32'hC0 + i, 1'b0);
        rd_burst(13'h000, 1, 3'b001, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++)
            check("badsize", 64'({g_last[i], g_resp[i], g_data[i]}), 64'({1'(i == 1), 2'b10, 32'h0}));
        rd_burst(13'h1000, 0, 3'b010, 1'b0, 1'b0);
        check("badsize_level", 64'(g_data[0]), 64'h4);
        rd_burst(13'h000, 3, 3'b010, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++)
            check("stall_order", 64'({g_resp[i], g_data[i]}), 64'({2'b00, 32'hC0 + i}));

        // Full / backpressure on the depth-4 instance
        feed_on = 1'b1;
        repeat (10) @(negedge ACLK);
        check("full_acc4", 64'(n_acc), 64'd4);
        check("full_tready", 64'(tready_s), 64'd0);
        rd_burst(13'h1000, 0, 3'b010, 1'b0, 1'b0);
        check("full_level", 64'(g_sdata[0]), 64'h4);
        rd_burst(13'h000, 0, 3'b010, 1'b0, 1'b0);
        check("full_pop1", 64'({g_sresp[0], g_sdata[0]}), 64'({2'b00, 32'hB0}));
        repeat (3) @(negedge ACLK);
        check("full_acc5", 64'(n_acc), 64'd5);
        check("full_tready2", 64'(tready_s), 64'd0);
        rd_burst(13'h000, 3, 3'b010, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++)
            check("full_drain", 64'({g_sresp[i], g_sdata[i]}), 64'({2'b00, 32'hB1 + i}));
        repeat (3) @(negedge ACLK);
        check("full_acc6", 64'(n_acc), 64'd6);
        rd_burst(13'h000, 0, 3'b010, 1'b0, 1'b0);
        check("full_last", 64'({g_sresp[0], g_sdata[0]}), 64'({2'b00, 32'hB5}));
        rd_burst(13'h1000, 0, 3'b010, 1'b0, 1'b0);
        check("full_empty", 64'(g_sdata[0]), 64'h0);

        // Reset mid-burst
        for (int i = 0; i < 8; i++) push(32'hF0 + i, 1'b0);
        araddr = 13'h000; arlen = 8'd7; arsize = 3'b010; arvalid = 1'b1; rready = 1'b1;
        c = 0;
        while (!arready && c < 20) begin @(negedge ACLK); c++; end
        @(negedge ACLK);
        arvalid = 1'b0;
        g_nb = 0; c = 0;
        while (g_nb < 3 && c < 50) begin
            if (rvalid) g_nb++;
            @(negedge ACLK);
            c++;
        end
        check("mid_beats3", 64'(g_nb), 64'd3);
        ARESET = 1'b1;
        #1;
        check("mid_rvalid", 64'(rvalid), 64'd0);
        check("mid_tready", 64'(tready), 64'd0);
        @(negedge ACLK);
        ARESET = 1'b0;
        check("mid_arready0", 64'(arready), 64'd0);
        @(negedge ACLK);
        check("mid_arready1", 64'(arready), 64'd1);
        rd_burst(13'h1000, 0, 3'b010, 1'b0, 1'b0);
        check("mid_level0", 64'({g_resp[0], g_data[0]}), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
